he_lb_csr_multi_ch: RTL and testbench
=====================================

Name: he_lb_csr_multi_ch

Overview:
Multi-channel host-exerciser loopback CSR block. It generalises the single-engine HE-LB register map to NUM_CH independent channels, one 4 KB window per channel, each window carrying a DFH in a linked feature chain. It sits between the MMIO slave adapter and NUM_CH loopback engines. It drives per-channel configuration and start/reset controls, and collects per-channel status counters, an inactivity timeout and sticky errors.

Parameters:
NUM_CH, 2, number of channels (1..8); window n lives at byte offset n*0x1000
CLK_MHZ, 500, reported in INFO0[15:0]
API_VER, 8'h02, reported in INFO0[23:16]
ATOMICS, 0, reported in INFO0[24]
BUS_W_SHIFT, 1, reported in INFO0[26:25] (PCIe bus bytes = 32 << value)
LM_W_SHIFT, 4, reported in INFO0[31:27] (local-memory bus bytes = 4 << value)
AFU_ID, 128'h56e203e9_864f_49a7_b94b_12284c31e02b, returned by ID_L/ID_H

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
wr_valid  in  1  write request
wr_addr  in  16  byte address
wr_dw  in  1  1 = 32-bit write, 0 = 64-bit write
wr_data  in  64  write data; for a 32-bit write the active lane is selected by wr_addr[2]
rd_valid  in  1  read request
rd_addr  in  16  byte address (64-bit aligned; reads are always 64-bit)
rd_tag  in  10  request tag
rsp_valid  out  1  read response
rsp_tag  out  10  echoed tag
rsp_data  out  64  read data
ch_rst_n  out  NUM_CH  engine reset release (CTL[0])
ch_start  out  NUM_CH  1-cycle start pulse
ch_src, ch_dst  out  NUM_CH*64  SRC_ADDR / DST_ADDR
ch_num_lines, ch_stride  out  NUM_CH*32  NUM_LINES / STRIDE
ch_cfg  out  NUM_CH*64  CFG
ch_busy  in  NUM_CH  engine busy
ch_rd_done, ch_wr_done  in  NUM_CH  1-cycle completion pulses
ch_err_set  in  NUM_CH*8  error set pulses, one bit per error cause
ch_timeout  out  NUM_CH  inactivity timeout flag (ERROR[31])

Behaviour:
- Decode: channel index = addr[15:12]; offset = addr[11:0]. Offsets: DFH 0x0, ID_L 0x8, ID_H 0x10, SCRATCHPAD0/1/2 at 0x100/0x104/0x108, DSM_BASE 0x110, SRC 0x120, DST 0x128, NUM_LINES 0x130, CTL 0x138, CFG 0x140, INACT_THRESH 0x148, STATUS0 0x160, STATUS1 0x168, ERROR 0x170, STRIDE 0x178, INFO0 0x180.
- Accesses to a channel index >= NUM_CH or to an undefined offset: reads return 0, writes are dropped.
- Writes:
  - Commit on the accept edge.
  - A 64-bit write with addr[2]=1 is dropped.
  - A 32-bit write to a 64-bit register updates only the addressed half.
  - RO registers (DFH, ID, STATUS, INFO0) ignore writes.
- Reads:
  - No backpressure; one request accepted per cycle.
  - Fixed 2-cycle latency: rsp_valid asserts exactly 2 cycles after rd_valid, with the matching tag.
  - A read and a write to the same register in the same cycle return the pre-write value.
- DFH, channel n: type 4'h1, EOL = (n==NUM_CH-1), next-offset = EOL ? 0 : 24'h1000.
- CTL:
  - bit0 drives ch_rst_n.
  - A 0->1 write of bit1 while bit0=1 produces one ch_start pulse on the following cycle.
  - bit1 reads back as written.
  - Writing bit1 while bit0=0 gives no pulse.
- On a ch_start pulse: STATUS0, STATUS1 and the inactivity counter clear.
- STATUS0: {num_writes[31:0], num_reads[31:0]}. Increments on ch_wr_done / ch_rd_done and saturates at 32'hFFFF_FFFF.
- Inactivity counter (32 bits):
  - Counts cycles with ch_busy=1 and no done pulse; clears on any done pulse.
  - When the count reaches INACT_THRESH (and INACT_THRESH != 0), ERROR[31] sets.
  - INACT_THRESH = 0 disables the timeout.
- ERROR:
  - Bits [7:0] and [31] are sticky and write-1-to-clear; ERROR[31] also drives ch_timeout.
  - ch_err_set ORs into ERROR[7:0].
  - If a set and a clear of the same bit occur in the same cycle, the set wins.
- CTL[0]=0 holds STATUS0, STATUS1 and the inactivity counter at 0. It does not clear ERROR or the config registers.
- Reset values: all registers 0 except INACT_THRESH = 32'hFFFF_FFFF. Outputs on reset: rsp_valid=0, ch_start=0, ch_rst_n=0, ch_timeout=0.
- Reset asserted mid-read: the in-flight response is dropped; no rsp_valid is issued for it.

Optional Feature:
HE_LB_CSR_PERF_EN
- Defined: STATUS1 is a 64-bit per-channel counter of cycles with ch_busy=1, cleared by ch_start, saturating.
- Undefined: STATUS1 reads 0 and the counter logic is absent.

Test Plan:
- Reset, then read 0x0000 / 0x1000 with NUM_CH=2 -> DFH EOL=0 with next-offset 0x1000 / DFH EOL=1 with next-offset 0; rsp_valid exactly 2 cycles after each request, tags echoed.
- 32-bit write 0xDEADBEEF to 0x1104, then 64-bit read of 0x1100 -> 64'hDEADBEEF_00000000; channel 0 scratchpad unchanged.
- Write CTL=1, then CTL=3 on channel 1 -> exactly one ch_start[1] pulse. Then 5 ch_rd_done and 3 ch_wr_done -> STATUS0 = 64'h3_00000005.
- INACT_THRESH=10, ch_busy held high with no done pulses -> ERROR[31] and ch_timeout set on the 10th idle cycle. Write ERROR=0x8000_0000 -> both cleared.
- ch_err_set bit2 asserted in the same cycle as a W1C write of bit2 -> ERROR[2] remains 1.
- Read of 0x3000 (channel 3, NUM_CH=2) -> data 0; write to 0x3100 is dropped; channel 0/1 registers unchanged.

Source files
------------

// File: rtl/he_lb_csr_multi_ch.sv
// he_lb_csr_multi_ch: multi-channel host-exerciser loopback CSR block.
// One 4 KB register window per channel (channel = addr[15:12]), each with a
// DFH linked into a feature chain. Per channel it holds the engine config,
// the CTL start/reset controls, status counters, an inactivity timeout and
// sticky errors.
// Optional build macro HE_LB_CSR_PERF_EN: STATUS1 becomes a saturating
// 64-bit busy-cycle counter. Without it STATUS1 reads 0.
module he_lb_csr_multi_ch #(
   parameter int           NUM_CH      = 2,
   parameter int           CLK_MHZ     = 500,
   parameter logic [7:0]   API_VER     = 8'h02,
   parameter bit           ATOMICS     = 1'b0,
   parameter int           BUS_W_SHIFT = 1,
   parameter int           LM_W_SHIFT  = 4,
   parameter logic [127:0] AFU_ID      = 128'h56e203e9_864f_49a7_b94b_12284c31e02b
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wr_valid,
   input  logic [15:0]          wr_addr,
   input  logic                 wr_dw,
   input  logic [63:0]          wr_data,
   input  logic                 rd_valid,
   input  logic [15:0]          rd_addr,
   input  logic [9:0]           rd_tag,
   output logic                 rsp_valid,
   output logic [9:0]           rsp_tag,
   output logic [63:0]          rsp_data,
   output logic [NUM_CH-1:0]    ch_rst_n,
   output logic [NUM_CH-1:0]    ch_start,
   output logic [NUM_CH*64-1:0] ch_src,
   output logic [NUM_CH*64-1:0] ch_dst,
   output logic [NUM_CH*32-1:0] ch_num_lines,
   output logic [NUM_CH*32-1:0] ch_stride,
   output logic [NUM_CH*64-1:0] ch_cfg,
   input  logic [NUM_CH-1:0]    ch_busy,
   input  logic [NUM_CH-1:0]    ch_rd_done,
   input  logic [NUM_CH-1:0]    ch_wr_done,
   input  logic [NUM_CH*8-1:0]  ch_err_set,
   output logic [NUM_CH-1:0]    ch_timeout
);

   localparam logic [31:0] INFO0 = {5'(LM_W_SHIFT), 2'(BUS_W_SHIFT), ATOMICS, API_VER, 16'(CLK_MHZ)};

   // A 64-bit write with addr[2]=1 is not a legal access and is dropped.
   // The 32-bit lane comes straight from the matching half of wr_data, so
   // the lane choice reduces to per-half write enables.
   logic        wr_ok, wr_lo, wr_hi;
   logic [11:0] wr_off, rd_off;
   logic [3:0]  rd_ch;
   logic [NUM_CH*64-1:0] rd_word_all;
   logic [63:0] rd_word;
   logic        rd_v1_reg, rsp_valid_reg;
   logic [9:0]  rd_tag1_reg, rsp_tag_reg;
   logic [63:0] rd_data1_reg, rsp_data_reg;
   logic        unused_bits;

   assign wr_ok  = wr_valid && (wr_dw || !wr_addr[2]);
   assign wr_lo  = !wr_dw || !wr_addr[2];
   assign wr_hi  = !wr_dw || wr_addr[2];
   assign wr_off = {wr_addr[11:3], 3'b000};
   assign rd_off = {rd_addr[11:3], 3'b000};
   assign rd_ch  = rd_addr[15:12];
   assign unused_bits = ^{wr_addr[1:0], rd_addr[2:0]};

   function automatic logic [63:0] merge64(input logic [63:0] old, input logic lo,
                                           input logic hi, input logic [63:0] d);
      return {hi ? d[63:32] : old[63:32], lo ? d[31:0] : old[31:0]};
   endfunction

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         localparam logic        EOL      = (gi == NUM_CH - 1);
         localparam logic [23:0] NEXT_OFF = EOL ? 24'h0 : 24'h1000;
         localparam logic [63:0] DFH_WORD = {4'h1, 19'h0, EOL, NEXT_OFF, 16'h0};

         logic        wr_sel, done_any, inact_fire;
         logic [63:0] scratch_reg, dsm_reg, src_reg, dst_reg, cfg_reg;
         logic [31:0] scratch2_reg, lines_reg, thresh_reg, stride_reg;
         logic [1:0]  ctl_reg;
         logic        start_reg, tmo_reg;
         logic [7:0]  err_reg;
         logic [31:0] rd_cnt_reg, wr_cnt_reg, inact_reg, inact_inc, err_clr;
         logic [63:0] status1, ch_rd;

         assign wr_sel   = wr_ok && (wr_addr[15:12] == 4'(gi));
         assign done_any = ch_rd_done[gi] || ch_wr_done[gi];
         assign inact_inc = inact_reg + 32'd1;
         // Fire once, on the busy cycle that brings the idle count up to the threshold.
         assign inact_fire = ctl_reg[0] && !start_reg && ch_busy[gi] && !done_any &&
                             (inact_reg != '1) && (thresh_reg != '0) && (inact_inc == thresh_reg);
         assign err_clr = (wr_sel && wr_off == 12'h170 && wr_lo) ? wr_data[31:0] : 32'h0;

         // Writable configuration registers and CTL.
         always_ff @(posedge clk) begin
            if (rst) begin
               scratch_reg  <= '0;
               scratch2_reg <= '0;
               dsm_reg      <= '0;
               src_reg      <= '0;
               dst_reg      <= '0;
               lines_reg    <= '0;
               ctl_reg      <= '0;
               cfg_reg      <= '0;
               thresh_reg   <= '1;
               stride_reg   <= '0;
            end else if (wr_sel) begin
               case (wr_off)
                  12'h100: scratch_reg <= merge64(scratch_reg, wr_lo, wr_hi, wr_data);
                  12'h108: if (wr_lo) scratch2_reg <= wr_data[31:0];
                  12'h110: dsm_reg <= merge64(dsm_reg, wr_lo, wr_hi, wr_data);
                  12'h120: src_reg <= merge64(src_reg, wr_lo, wr_hi, wr_data);
                  12'h128: dst_reg <= merge64(dst_reg, wr_lo, wr_hi, wr_data);
                  12'h130: if (wr_lo) lines_reg <= wr_data[31:0];
                  12'h138: if (wr_lo) ctl_reg <= wr_data[1:0];
                  12'h140: cfg_reg <= merge64(cfg_reg, wr_lo, wr_hi, wr_data);
                  12'h148: if (wr_lo) thresh_reg <= wr_data[31:0];
                  12'h178: if (wr_lo) stride_reg <= wr_data[31:0];
                  default: ;
               endcase
            end
         end

         // Start pulse: CTL[1] rising by a write while the engine is out of reset.
         always_ff @(posedge clk) begin
            if (rst) start_reg <= 1'b0;
            else     start_reg <= wr_sel && (wr_off == 12'h138) && wr_lo && ctl_reg[0] &&
                                  !ctl_reg[1] && wr_data[1];
         end

         // Completion counters and inactivity counter; held clear in reset or on start.
         always_ff @(posedge clk) begin
            if (rst || !ctl_reg[0] || start_reg) begin
               rd_cnt_reg <= '0;
               wr_cnt_reg <= '0;
               inact_reg  <= '0;
            end else begin
               if (ch_rd_done[gi] && rd_cnt_reg != '1) rd_cnt_reg <= rd_cnt_reg + 32'd1;
               if (ch_wr_done[gi] && wr_cnt_reg != '1) wr_cnt_reg <= wr_cnt_reg + 32'd1;
               if (done_any)                              inact_reg <= '0;
               else if (ch_busy[gi] && inact_reg != '1)   inact_reg <= inact_inc;
            end
         end

         // Sticky W1C errors; a same-cycle set beats the clear.
         always_ff @(posedge clk) begin
            if (rst) begin
               err_reg <= '0;
               tmo_reg <= 1'b0;
            end else begin
               err_reg <= (err_reg & ~err_clr[7:0]) | ch_err_set[gi*8 +: 8];
               tmo_reg <= (tmo_reg & ~err_clr[31]) | inact_fire;
            end
         end

`ifdef HE_LB_CSR_PERF_EN
         logic [63:0] perf_reg;
         // Busy-cycle counter, saturating.
         always_ff @(posedge clk) begin
            if (rst || !ctl_reg[0] || start_reg) perf_reg <= '0;
            else if (ch_busy[gi] && perf_reg != '1) perf_reg <= perf_reg + 64'd1;
         end
         assign status1 = perf_reg;
`else
         assign status1 = '0;
`endif

         // Per-channel read decode of the 64-bit word at rd_off.
         always_comb begin
            ch_rd = '0;
            case (rd_off)
               12'h000: ch_rd = DFH_WORD;
               12'h008: ch_rd = AFU_ID[63:0];
               12'h010: ch_rd = AFU_ID[127:64];
               12'h100: ch_rd = scratch_reg;
               12'h108: ch_rd = {32'h0, scratch2_reg};
               12'h110: ch_rd = dsm_reg;
               12'h120: ch_rd = src_reg;
               12'h128: ch_rd = dst_reg;
               12'h130: ch_rd = {32'h0, lines_reg};
               12'h138: ch_rd = {62'h0, ctl_reg};
               12'h140: ch_rd = cfg_reg;
               12'h148: ch_rd = {32'h0, thresh_reg};
               12'h160: ch_rd = {wr_cnt_reg, rd_cnt_reg};
               12'h168: ch_rd = status1;
               12'h170: ch_rd = {32'h0, tmo_reg, 23'h0, err_reg};
               12'h178: ch_rd = {32'h0, stride_reg};
               12'h180: ch_rd = {32'h0, INFO0};
               default: ch_rd = '0;
            endcase
         end

         assign rd_word_all[gi*64 +: 64]  = ch_rd;
         assign ch_rst_n[gi]              = ctl_reg[0];
         assign ch_start[gi]              = start_reg;
         assign ch_src[gi*64 +: 64]       = src_reg;
         assign ch_dst[gi*64 +: 64]       = dst_reg;
         assign ch_num_lines[gi*32 +: 32] = lines_reg;
         assign ch_stride[gi*32 +: 32]    = stride_reg;
         assign ch_cfg[gi*64 +: 64]       = cfg_reg;
         assign ch_timeout[gi]            = tmo_reg;
      end
   endgenerate

   // Channel select; indices with no channel read as zero.
   always_comb begin
      rd_word = '0;
      for (int i = 0; i < NUM_CH; i++)
         if (rd_ch == 4'(i)) rd_word = rd_word_all[i*64 +: 64];
   end

   // Two-stage read pipeline; reset drops anything in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_v1_reg     <= 1'b0;
         rsp_valid_reg <= 1'b0;
      end else begin
         rd_v1_reg     <= rd_valid;
         rsp_valid_reg <= rd_v1_reg;
      end
      rd_tag1_reg  <= rd_tag;
      rd_data1_reg <= rd_word;
      rsp_tag_reg  <= rd_tag1_reg;
      rsp_data_reg <= rd_data1_reg;
   end

   assign rsp_valid = rsp_valid_reg;
   assign rsp_tag   = rsp_tag_reg;
   assign rsp_data  = rsp_data_reg;

endmodule

// File: tb/tb_he_lb_csr_multi_ch.sv
// tb_he_lb_csr_multi_ch: directed plus randomized checks of he_lb_csr_multi_ch
// against a register-image reference model kept in the bench.
module tb_he_lb_csr_multi_ch;
   localparam int NUM_CH = 2;
   localparam logic [127:0] AFU_ID = 128'h56e203e9_864f_49a7_b94b_12284c31e02b;

   logic                 clk = 0, rst = 1;
   logic                 wr_valid = 0, wr_dw = 0, rd_valid = 0;
   logic [15:0]          wr_addr = 0, rd_addr = 0;
   logic [63:0]          wr_data = 0;
   logic [9:0]           rd_tag = 0;
   logic                 rsp_valid;
   logic [9:0]           rsp_tag;
   logic [63:0]          rsp_data;
   logic [NUM_CH-1:0]    ch_rst_n, ch_start, ch_timeout;
   logic [NUM_CH*64-1:0] ch_src, ch_dst, ch_cfg;
   logic [NUM_CH*32-1:0] ch_num_lines, ch_stride;
   logic [NUM_CH-1:0]    ch_busy = 0, ch_rd_done = 0, ch_wr_done = 0;
   logic [NUM_CH*8-1:0]  ch_err_set = 0;

   he_lb_csr_multi_ch #(.NUM_CH(NUM_CH)) dut (
      .clk(clk), .rst(rst),
      .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_dw(wr_dw), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_tag(rd_tag),
      .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_data(rsp_data),
      .ch_rst_n(ch_rst_n), .ch_start(ch_start), .ch_src(ch_src), .ch_dst(ch_dst),
      .ch_num_lines(ch_num_lines), .ch_stride(ch_stride), .ch_cfg(ch_cfg),
      .ch_busy(ch_busy), .ch_rd_done(ch_rd_done), .ch_wr_done(ch_wr_done),
      .ch_err_set(ch_err_set), .ch_timeout(ch_timeout)
   );

   always #5 clk = ~clk;

   // Reference model: a register image per channel plus the behavioural state.
   logic [63:0] img    [NUM_CH][512];
   logic [7:0]  m_err  [NUM_CH];
   logic        m_tmo  [NUM_CH];
   logic [31:0] m_rd   [NUM_CH];
   logic [31:0] m_wr   [NUM_CH];
   logic [63:0] m_busy [NUM_CH];
   int          start_cnt [NUM_CH] = '{default: 0};
   int          checks = 0, errors = 0;

   always @(posedge clk)
      for (int i = 0; i < NUM_CH; i++)
         if (ch_start[i]) start_cnt[i] <= start_cnt[i] + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Bits that software can write at each 64-bit aligned offset.
   function automatic logic [63:0] wmask(input logic [11:0] off);
      case (off)
         12'h100, 12'h110, 12'h120, 12'h128, 12'h140: return 64'hFFFF_FFFF_FFFF_FFFF;
         12'h108, 12'h130, 12'h148, 12'h178:          return 64'h0000_0000_FFFF_FFFF;
         12'h138:                                     return 64'h3;
         default:                                     return 64'h0;
      endcase
   endfunction

   task automatic mdl_reset();
      for (int c = 0; c < NUM_CH; c++) begin
         for (int w = 0; w < 512; w++) img[c][w] = 64'h0;
         img[c][12'h148 >> 3] = 64'hFFFF_FFFF;
         m_err[c] = 0; m_tmo[c] = 0; m_rd[c] = 0; m_wr[c] = 0; m_busy[c] = 0;
      end
   endtask

   task automatic mdl_write(input logic [15:0] a, input logic dw, input logic [63:0] d);
      int c;
      logic [11:0] off;
      logic [63:0] lane, m;
      c = int'(a[15:12]);
      off = {a[11:3], 3'b000};
      if (c >= NUM_CH) return;
      if (!dw && a[2]) return;
      lane = !dw ? 64'hFFFF_FFFF_FFFF_FFFF : (a[2] ? 64'hFFFF_FFFF_0000_0000 : 64'h0000_0000_FFFF_FFFF);
      if (off == 12'h170) begin
         m_err[c] = m_err[c] & ~(d[7:0] & lane[7:0]);
         if (d[31] && lane[31]) m_tmo[c] = 0;
      end else begin
         m = wmask(off) & lane;
         img[c][off[11:3]] = (img[c][off[11:3]] & ~m) | (d & m);
      end
   endtask

   function automatic logic [63:0] mdl_read(input logic [15:0] a);
      int c;
      logic [11:0] off;
      logic [63:0] r;
      c = int'(a[15:12]);
      off = {a[11:3], 3'b000};
      if (c >= NUM_CH) return 64'h0;
      case (off)
         12'h000: begin
            r = 64'h1 << 60;
            if (c == NUM_CH - 1) r = r | (64'h1 << 40);
            else                 r = r | (64'h1000 << 16);
            return r;
         end
         12'h008: return AFU_ID[63:0];
         12'h010: return AFU_ID[127:64];
         12'h160: return {m_wr[c], m_rd[c]};
`ifdef HE_LB_CSR_PERF_EN
         12'h168: return m_busy[c];
`endif
         12'h170: return {32'h0, m_tmo[c], 23'h0, m_err[c]};
         12'h180: return 64'((4 << 27) | (1 << 25) | (0 << 24) | (2 << 16) | 500);
         default: return img[c][off[11:3]] & wmask(off);
      endcase
   endfunction

   task automatic wr(input logic [15:0] a, input logic dw, input logic [63:0] d);
      wr_valid = 1; wr_addr = a; wr_dw = dw; wr_data = d;
      @(posedge clk); #1;
      wr_valid = 0;
      mdl_write(a, dw, d);
      $display("wr   addr=%h dw=%0d data=%h", a, dw, d);
   endtask

   task automatic rd(input logic [15:0] a, input string tag);
      logic [63:0] exp;
      logic [9:0]  t;
      exp = mdl_read(a);
      t = 10'($urandom);
      rd_valid = 1; rd_addr = a; rd_tag = t;
      @(posedge clk); #1;
      rd_valid = 0;
      check({tag, "_early"}, 64'(rsp_valid), 64'h0);
      @(posedge clk); #1;
      check({tag, "_valid"}, 64'(rsp_valid), 64'h1);
      check({tag, "_tag"}, 64'(rsp_tag), 64'(t));
      check(tag, rsp_data, exp);
      $display("rd   addr=%h tag=%h data=%h", a, rsp_tag, rsp_data);
   endtask

   initial begin
      int offs[15] = '{12'h000, 12'h008, 12'h100, 12'h108, 12'h110, 12'h120, 12'h128, 12'h130,
                       12'h140, 12'h148, 12'h150, 12'h160, 12'h178, 12'h180, 12'h1F8};
      logic [15:0] a;
      logic [63:0] d, exp;
      logic [9:0]  t;
      logic [7:0]  eset;

      mdl_reset();
      repeat (3) @(posedge clk);
      #1 rst = 0;
      check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
      check("rst_ch_start", 64'(ch_start), 64'h0);
      check("rst_ch_rst_n", 64'(ch_rst_n), 64'h0);
      check("rst_ch_timeout", 64'(ch_timeout), 64'h0);

      // DFH chain, IDs, INFO0, reset value of INACT_THRESH.
      rd(16'h0000, "dfh0");
      rd(16'h1000, "dfh1");
      rd(16'h0008, "id_l");
      rd(16'h1010, "id_h");
      rd(16'h1180, "info0");
      rd(16'h0148, "thresh_rst");

      // 32-bit write to the upper scratchpad of channel 1.
      wr(16'h1104, 1, {32'hDEADBEEF, 32'($urandom)});
      rd(16'h1100, "scratch1");
      rd(16'h0100, "scratch0");

      // Random writes over RW, RO, undefined and out-of-range locations.
      for (int i = 0; i < 40; i++) begin
         a = {4'($urandom_range(0, 3)), 9'(offs[$urandom_range(0, 14)] >> 3), 1'($urandom_range(0, 1)), 2'b00};
         wr(a, 1'($urandom_range(0, 1)), {32'($urandom), 32'($urandom)});
      end
      for (int c = 0; c < 3; c++)
         for (int k = 0; k < 15; k++)
            rd({4'(c), 12'(offs[k])}, $sformatf("rand_c%0d_%h", c, offs[k]));
      for (int c = 0; c < NUM_CH; c++) begin
         check($sformatf("src%0d", c), ch_src[c*64 +: 64], img[c][12'h120 >> 3]);
         check($sformatf("dst%0d", c), ch_dst[c*64 +: 64], img[c][12'h128 >> 3]);
         check($sformatf("cfg%0d", c), ch_cfg[c*64 +: 64], img[c][12'h140 >> 3]);
         check($sformatf("lines%0d", c), 64'(ch_num_lines[c*32 +: 32]), img[c][12'h130 >> 3] & 64'hFFFF_FFFF);
         check($sformatf("stride%0d", c), 64'(ch_stride[c*32 +: 32]), img[c][12'h178 >> 3] & 64'hFFFF_FFFF);
      end

      // CTL: reset release, single start pulse, no pulse without reset release.
      wr(16'h1138, 0, 64'h1);
      check("ctl_rst_n", 64'(ch_rst_n), 64'h2);
      check("ctl_no_start", 64'(ch_start), 64'h0);
      wr(16'h1138, 0, 64'h3);
      check("start_pulse", 64'(ch_start), 64'h2);
      @(posedge clk); #1;
      check("start_one_cycle", 64'(ch_start), 64'h0);
      wr(16'h0138, 0, 64'h2);
      wr(16'h1138, 0, 64'h3);
      repeat (3) @(posedge clk); #1;
      check("start_cnt1", 64'(start_cnt[1]), 64'h1);
      check("start_cnt0", 64'(start_cnt[0]), 64'h0);
      check("ctl0_rst_n", 64'(ch_rst_n), 64'h2);
      rd(16'h0138, "ctl0_rb");

      // Completion pulses: channel 1 counts, channel 0 is held in reset.
      begin
         int nrd = 5, nwr = 3;
         logic pick_rd;
         while (nrd + nwr > 0) begin
            pick_rd = (nwr == 0) || (nrd != 0 && $urandom_range(0, 1) == 1);
            ch_rd_done = {pick_rd, 1'($urandom_range(0, 1))};
            ch_wr_done = {!pick_rd, 1'($urandom_range(0, 1))};
            if (pick_rd) begin nrd--; m_rd[1]++; end
            else         begin nwr--; m_wr[1]++; end
            @(posedge clk); #1;
            ch_rd_done = 0; ch_wr_done = 0;
            if ($urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
         end
      end
      rd(16'h1160, "status0_c1");
      check("status0_value", mdl_read(16'h1160), 64'h3_0000_0005);
      rd(16'h0160, "status0_c0");

      // Inactivity timeout at a threshold of 10 busy cycles.
      wr(16'h1148, 1, 64'hFFFF_0000_0000_000A);
      ch_busy = 2'b10;
      for (int i = 1; i <= 10; i++) begin
         @(posedge clk); #1;
         if (i == 9) check("tmo_before", 64'(ch_timeout), 64'h0);
      end
      check("tmo_set", 64'(ch_timeout), 64'h2);
      ch_busy = 0;
      m_busy[1] += 10;
      m_tmo[1] = 1;
      rd(16'h1170, "error_tmo");
      rd(16'h1168, "status1");
      wr(16'h1170, 0, 64'h8000_0000);
      check("tmo_cleared", 64'(ch_timeout), 64'h0);
      rd(16'h1170, "error_clr");

      // Error set versus W1C clear in the same cycle.
      ch_err_set[2] = 1;
      @(posedge clk); #1;
      ch_err_set = 0;
      m_err[0] |= 8'h04;
      rd(16'h0170, "err_set");
      ch_err_set[2] = 1;
      wr(16'h0170, 0, 64'h4);
      ch_err_set = 0;
      m_err[0] |= 8'h04;
      rd(16'h0170, "err_set_wins");
      wr(16'h0170, 1, 64'h4);
      rd(16'h0170, "err_w1c");
      eset = 8'($urandom);
      ch_err_set[15:8] = eset;
      @(posedge clk); #1;
      ch_err_set = 0;
      m_err[1] |= eset;
      rd(16'h1170, "err_rand");

      // Out-of-range channel.
      rd(16'h3000, "oor_read");
      wr(16'h3100, 0, {32'($urandom), 32'($urandom)});
      rd(16'h0100, "oor_c0");
      rd(16'h1100, "oor_c1");

      // Same-cycle read and write of one register returns the old value.
      exp = mdl_read(16'h0120);
      t = 10'($urandom);
      d = {32'($urandom), 32'($urandom)};
      rd_valid = 1; rd_addr = 16'h0120; rd_tag = t;
      wr_valid = 1; wr_addr = 16'h0120; wr_dw = 0; wr_data = d;
      @(posedge clk); #1;
      rd_valid = 0; wr_valid = 0;
      mdl_write(16'h0120, 0, d);
      @(posedge clk); #1;
      check("rw_valid", 64'(rsp_valid), 64'h1);
      check("rw_tag", 64'(rsp_tag), 64'(t));
      check("rw_old", rsp_data, exp);
      $display("rdwr addr=0120 tag=%h data=%h", rsp_tag, rsp_data);
      rd(16'h0120, "rw_new");

      // Reset while a read is in flight drops the response.
      rd_valid = 1; rd_addr = 16'h0008; rd_tag = 10'h155;
      @(posedge clk); #1;
      rd_valid = 0; rst = 1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check($sformatf("rst_drop%0d", i), 64'(rsp_valid), 64'h0);
      end
      rst = 0;
      mdl_reset();
      @(posedge clk); #1;
      check("rst2_valid", 64'(rsp_valid), 64'h0);
      check("rst2_rst_n", 64'(ch_rst_n), 64'h0);
      check("rst2_timeout", 64'(ch_timeout), 64'h0);
      rd(16'h1148, "rst2_thresh");
      rd(16'h1100, "rst2_scratch");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
